// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcode/funct encodings, architectural
// register numbers and the stall controller state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } stall_state_t;

endpackage

// File: rtl/src_decode.sv
// Source-operand decode for the instruction in RF/ID: which register fields
// are actually read, and whether the instruction resolves in RF (branch/jr).
// Shared between the stall controller and the forwarding units.
module src_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic        is_branch
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       is_jr;
  logic       unused_imm;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign funct = instr[5:0];

  // rd/shamt/immediate bits never name a source register.
  assign unused_imm = ^instr[15:6];

  assign is_jr = (op == OP_RTYPE) && (funct == FUNCT_JR);

  // Jumps and lui carry no rs operand; everything else reads rs.
  assign uses_rs = !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI));

  // rt is a source only for R-type ALU ops, compare-branches and stores.
  assign uses_rt = ((op == OP_RTYPE) && !is_jr) ||
                   (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);

  assign is_branch = (op == OP_BEQ) || (op == OP_BNE) || is_jr;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// RF-stage interlock: stalls PC and IF/ID and bubbles ID/EX whenever an
// operand the RF instruction needs cannot be forwarded in time, and keeps a
// saturating count of stalled cycles.
module hazard_stall_ctrl
  import mips_pkg::*;
#(
  parameter int         CNT_W   = 16,
  parameter logic [4:0] RA_ADDR = REG_RA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      RF_Instruction,
  input  logic             EX_RegWr,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_RegDstAddr,
  input  logic             MEM_RegWr,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_RegDstAddr,
  output logic             PC_Stall,
  output logic             IF_ID_Stall,
  output logic             ID_EX_Bubble,
  output logic             Stall_Active,
  output logic [CNT_W-1:0] Stall_Count
);

  // jr waits on the link register through its ordinary rs path; a link
  // register of $0 would make that hazard invisible, since $0 never matches.
  if (RA_ADDR == REG_ZERO) begin : g_bad_ra
    $error("hazard_stall_ctrl: RA_ADDR must not be register zero");
  end

  stall_state_t state;
  logic [1:0]   remaining;

  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rs;
  logic       uses_rt;
  logic       is_branch;

  logic ex_hit;
  logic mem_hit;
  logic need_two;
  logic need_one;
  logic stall;

  src_decode u_src_decode (
    .instr     (RF_Instruction),
    .rs        (rs),
    .rt        (rt),
    .uses_rs   (uses_rs),
    .uses_rt   (uses_rt),
    .is_branch (is_branch)
  );

  // Classify the RF instruction's dependence on EX/MEM results into the
  // number of stall cycles needed before forwarding can cover it.
  // NOTE: every signal assigned here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ex_hit   = 1'b0;
    mem_hit  = 1'b0;
    need_two = 1'b0;
    need_one = 1'b0;

    if (uses_rs && (rs != REG_ZERO)) begin
      ex_hit  = ex_hit  | (EX_RegDstAddr  == rs);
      mem_hit = mem_hit | (MEM_RegDstAddr == rs);
    end
    if (uses_rt && (rt != REG_ZERO)) begin
      ex_hit  = ex_hit  | (EX_RegDstAddr  == rt);
      mem_hit = mem_hit | (MEM_RegDstAddr == rt);
    end

    if (is_branch) begin
      // Compare/jr happens in RF, so even an ALU result in EX is one cycle late.
      need_two = ex_hit && EX_RegWr && EX_MemRead;
      need_one = (ex_hit  && EX_RegWr  && !EX_MemRead) ||
                 (mem_hit && MEM_RegWr && MEM_MemRead);
    end else begin
      // ALU consumers only wait on load-use; ALU->ALU forwards from MEM.
      need_one = ex_hit && EX_RegWr && EX_MemRead;
    end
  end

  // In STALL the hazard inputs are ignored: EX already holds the bubble.
  assign stall = (state == STALL) || need_two || need_one;

  assign PC_Stall     = stall;
  assign IF_ID_Stall  = stall;
  assign ID_EX_Bubble = stall;
  assign Stall_Active = (state == STALL);

  // Stall FSM: single-cycle stalls are handled combinationally in IDLE; only
  // the extra cycles of a load-to-branch hazard are tracked in STALL.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (need_two) begin
            state     <= STALL;
            remaining <= 2'd1;
          end
        end
        STALL: begin
          if (remaining <= 2'd1) begin
            state     <= IDLE;
            remaining <= 2'd0;
          end else begin
            remaining <= remaining - 2'd1;
          end
        end
        default: begin
          state     <= IDLE;
          remaining <= 2'd0;
        end
      endcase
    end
  end

  // Performance counter: one tick per stalled cycle, pinned at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      Stall_Count <= '0;
    end else if (stall && (Stall_Count != {CNT_W{1'b1}})) begin
      Stall_Count <= Stall_Count + 1'b1;
    end
  end

endmodule
